// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings and line levels.
// The line levels are shared with the receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Parity bit for a byte. Unused upper bits must be zero so they
   // do not disturb the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the
// last cycle of every bit. Held at zero while clear is high.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Free-running within a frame; wraps to zero on each bit boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. The serial line is registered, so it lags
// the FSM state by exactly one clock.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   uart_state_t          r_state;
   uart_state_t          w_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic                 r_par;
   logic                 r_tx;
   logic                 w_tick;
   logic                 w_hs;
   logic                 w_clear;

   assign w_hs    = (r_state == ST_IDLE) && tx_valid;
   assign w_clear = (r_state == ST_IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .bit_tick(w_tick)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: every state except IDLE advances on a bit tick.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_hs) w_next = ST_START;
         ST_START:  if (w_tick) w_next = ST_DATA;
         ST_DATA: begin
            if (w_tick && (r_bit_cnt == LAST_DATA)) begin
               w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: if (w_tick) w_next = ST_STOP;
         ST_STOP:   if (w_tick && (r_bit_cnt == LAST_STOP)) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Datapath: byte capture at handshake, shifting, bit counting and the
   // registered line level derived from the current state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
         r_tx      <= IDLE_LEVEL;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx      <= IDLE_LEVEL;
               r_bit_cnt <= '0;
               if (w_hs) begin
                  r_shift <= tx_data;
                  r_par   <= parity_bit(8'(tx_data), PARITY);
               end
            end
            ST_START: begin
               r_tx <= START_LEVEL;
            end
            ST_DATA: begin
               r_tx <= r_shift[0];
               if (w_tick) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               r_tx <= r_par;
            end
            ST_STOP: begin
               r_tx <= IDLE_LEVEL;
               if (w_tick) begin
                  r_bit_cnt <= (r_bit_cnt == LAST_STOP) ? '0 : r_bit_cnt + 1'b1;
               end
            end
            default: begin
               r_tx <= IDLE_LEVEL;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign tx_ready = (r_state == ST_IDLE);
   assign busy     = (r_state != ST_IDLE);
   assign tx_done  = (r_state == ST_STOP) && w_tick && (r_bit_cnt == LAST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameterisations side by side, directed frames
// from the test plan plus random frames, all checked cycle by cycle against
// a bit-list model of the serial frame.
module tb_uart_tx;

   logic       clk;
   logic       reset;
   logic       tv [5];
   logic [7:0] td [5];
   logic       tx_o [5];
   logic       rdy [5];
   logic       bsy [5];
   logic       dn [5];

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx u_d0 (
      .clk(clk), .reset(reset), .tx_data(td[0]), .tx_valid(tv[0]),
      .tx_ready(rdy[0]), .tx(tx_o[0]), .busy(bsy[0]), .tx_done(dn[0]));

   uart_tx #(.PARITY(1)) u_d1 (
      .clk(clk), .reset(reset), .tx_data(td[1]), .tx_valid(tv[1]),
      .tx_ready(rdy[1]), .tx(tx_o[1]), .busy(bsy[1]), .tx_done(dn[1]));

   uart_tx #(.PARITY(2)) u_d2 (
      .clk(clk), .reset(reset), .tx_data(td[2]), .tx_valid(tv[2]),
      .tx_ready(rdy[2]), .tx(tx_o[2]), .busy(bsy[2]), .tx_done(dn[2]));

   uart_tx #(.STOP_BITS(2)) u_d3 (
      .clk(clk), .reset(reset), .tx_data(td[3]), .tx_valid(tv[3]),
      .tx_ready(rdy[3]), .tx(tx_o[3]), .busy(bsy[3]), .tx_done(dn[3]));

   uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) u_d4 (
      .clk(clk), .reset(reset), .tx_data(td[4][4:0]), .tx_valid(tv[4]),
      .tx_ready(rdy[4]), .tx(tx_o[4]), .busy(bsy[4]), .tx_done(dn[4]));

   function automatic int cpb(input int k);
      return (k == 4) ? 3 : 10;
   endfunction

   function automatic int dbits(input int k);
      return (k == 4) ? 5 : 8;
   endfunction

   function automatic int par(input int k);
      case (k)
         1:       return 1;
         2, 4:    return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int sbits(input int k);
      return (k == 3 || k == 4) ? 2 : 1;
   endfunction

   function automatic int flen(input int k);
      return (1 + dbits(k) + ((par(k) != 0) ? 1 : 0) + sbits(k)) * cpb(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive (optionally) a handshake on instance k and check the whole frame.
   // mode 0: drop valid after handshake; 1: hold valid with nxt for a
   // back-to-back frame; 2: hold valid with nxt during the frame and drop it
   // before the frame ends (must be ignored).
   task automatic run_frame(input int k, input logic [7:0] data, input bit do_hs,
                            input int mode, input logic [7:0] nxt);
      bit bits[$];
      int ones;
      int L;
      int w;
      L    = flen(k);
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < dbits(k); i++) begin
         bits.push_back(data[i]);
         ones += data[i];
      end
      if (par(k) == 1) bits.push_back(bit'(ones % 2));
      if (par(k) == 2) bits.push_back(bit'(1 - ones % 2));
      for (int i = 0; i < sbits(k); i++) bits.push_back(1'b1);

      if (do_hs) begin
         tv[k] = 1'b1;
         td[k] = data;
         w = 0;
         while (!rdy[k] && w < 4 * L) begin
            @(posedge clk); #1;
            w++;
         end
         if (!rdy[k]) begin
            check($sformatf("d%0d_hs_timeout", k), rdy[k], 1);
            tv[k] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end

      check($sformatf("d%0d_hs_busy", k), bsy[k], 1);
      check($sformatf("d%0d_hs_ready", k), rdy[k], 0);
      check($sformatf("d%0d_hs_tx", k), tx_o[k], 1);
      if (mode == 0) begin
         tv[k] = 1'b0;
         td[k] = 8'($urandom);
      end else begin
         tv[k] = 1'b1;
         td[k] = nxt;
      end

      for (int c = 1; c <= L; c++) begin
         @(posedge clk); #1;
         check($sformatf("d%0d_tx_c%0d", k, c), tx_o[k], bits[(c - 1) / cpb(k)]);
         check($sformatf("d%0d_done_c%0d", k, c), dn[k], (c == L - 1) ? 1 : 0);
         check($sformatf("d%0d_busy_c%0d", k, c), bsy[k], (c <= L - 1) ? 1 : 0);
         check($sformatf("d%0d_ready_c%0d", k, c), rdy[k], (c <= L - 1) ? 0 : 1);
         if (mode == 2 && c == L - 1) tv[k] = 1'b0;
      end

      @(posedge clk); #1;
      check($sformatf("d%0d_gap_tx", k), tx_o[k], 1);
      check($sformatf("d%0d_gap_busy", k), bsy[k], (mode == 1) ? 1 : 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      bit chained;
      logic [7:0] cur;
      logic [7:0] nx;
      int mode;

      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tv[k] = 1'b0;
         td[k] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("d%0d_rst_tx", k), tx_o[k], 1);
         check($sformatf("d%0d_rst_ready", k), rdy[k], 1);
         check($sformatf("d%0d_rst_busy", k), bsy[k], 0);
         check($sformatf("d%0d_rst_done", k), dn[k], 0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // 8N1 single frame, then back-to-back, then ignored valid mid-frame.
      run_frame(0, 8'h41, 1'b1, 0, 8'h00);
      run_frame(0, 8'h44, 1'b1, 1, 8'h55);
      run_frame(0, 8'h55, 1'b0, 0, 8'h00);
      run_frame(0, 8'h00, 1'b1, 2, 8'hFF);
      @(posedge clk); #1;
      check("d0_ignored_busy", bsy[0], 0);

      // Parity variants.
      run_frame(1, 8'h07, 1'b1, 0, 8'h00);
      run_frame(2, 8'h07, 1'b1, 0, 8'h00);

      // Reset during data bit 4 of 0xA5.
      tv[0] = 1'b1;
      td[0] = 8'hA5;
      @(posedge clk); #1;
      tv[0] = 1'b0;
      repeat (55) @(posedge clk);
      #1;
      check("d0_pre_rst_bit4", tx_o[0], 0);
      #2;
      reset = 1'b0;
      #1;
      check("d0_mid_rst_tx", tx_o[0], 1);
      check("d0_mid_rst_busy", bsy[0], 0);
      check("d0_mid_rst_ready", rdy[0], 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("d0_post_rst_tx", tx_o[0], 1);
      check("d0_post_rst_busy", bsy[0], 0);
      run_frame(0, 8'h3C, 1'b1, 0, 8'h00);

      // Two stop bits.
      run_frame(3, 8'h00, 1'b1, 0, 8'h00);

      // Random frames on every instance, some chained back-to-back.
      for (int k = 0; k < 5; k++) begin
         chained = 1'b0;
         cur = 8'($urandom);
         for (int f = 0; f < 8; f++) begin
            mode = (f == 7) ? 0 : int'($urandom_range(0, 1));
            nx = 8'($urandom);
            run_frame(k, cur, !chained, mode, nx);
            chained = (mode == 1);
            cur = chained ? nx : 8'($urandom);
            if (!chained) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
